bit_unstuffer: RTL

Receive-side counterpart of the USB transmit bit stuffer. It sits between the NRZI decoder and the receive shift register. On each sample strobe it takes one decoded bit and tracks runs of consecutive 1s. After RUN_LEN consecutive 1s it discards the following stuffed 0 and flags a stuff error if that bit is 1. Only genuine payload bits are forwarded, each with a one-cycle valid pulse.

---
 rtl/bit_unstuffer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/bit_unstuffer.sv
// Receive bit unstuffer: forwards payload bits and drops the 0 stuffed after RUN_LEN 1s; BIT_UNSTUFF_ERR_EN adds a sticky stuff_err and ERR state.
// Latency: one cycle from strobe to bit_valid/stuff_drop. No backpressure; accepts a strobe on every cycle.
module bit_unstuffer #(
    parameter int RUN_LEN = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic shift_strobe,
    input  logic d_orig,
    input  logic clear,
    output logic bit_out,
    output logic bit_valid,
    output logic stuff_drop,
    output logic stuff_err
);

    localparam int CW = $clog2(RUN_LEN + 1);
    localparam logic [CW-1:0] RUN_MAX = CW'(RUN_LEN);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CHECK = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_ones_cnt;
    logic [CW-1:0] w_ones_nxt;
    logic          r_bit_out;
    logic          w_bit_out_nxt;
    logic          r_bit_valid;
    logic          w_bit_valid_nxt;
    logic          r_stuff_drop;
    logic          w_stuff_drop_nxt;
`ifdef BIT_UNSTUFF_ERR_EN
    logic          r_stuff_err;
    logic          w_stuff_err_nxt;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= ST_RUN;
            r_ones_cnt   <= '0;
            r_bit_out    <= 1'b0;
            r_bit_valid  <= 1'b0;
            r_stuff_drop <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ones_cnt   <= w_ones_nxt;
            r_bit_out    <= w_bit_out_nxt;
            r_bit_valid  <= w_bit_valid_nxt;
            r_stuff_drop <= w_stuff_drop_nxt;
        end
    end

`ifdef BIT_UNSTUFF_ERR_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stuff_err <= 1'b0;
        end else begin
            r_stuff_err <= w_stuff_err_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_ones_nxt       = r_ones_cnt;
        w_bit_out_nxt    = r_bit_out;
        w_bit_valid_nxt  = 1'b0;
        w_stuff_drop_nxt = 1'b0;
`ifdef BIT_UNSTUFF_ERR_EN
        w_stuff_err_nxt  = r_stuff_err;
`endif
        // clear beats a coincident strobe; that sample is thrown away
        if (clear) begin
            w_state_nxt = ST_RUN;
            w_ones_nxt  = '0;
`ifdef BIT_UNSTUFF_ERR_EN
            w_stuff_err_nxt = 1'b0;
`endif
        end else if (shift_strobe) begin
            case (r_state)
                ST_RUN: begin
                    w_bit_valid_nxt = 1'b1;
                    w_bit_out_nxt   = d_orig;
                    if (d_orig) begin
                        if (r_ones_cnt < RUN_MAX) begin
                            w_ones_nxt = r_ones_cnt + 1'b1;
                        end
                        if (r_ones_cnt + 1'b1 == RUN_MAX) begin
                            w_state_nxt = ST_CHECK;
                        end
                    end else begin
                        w_ones_nxt = '0;
                    end
                end
                ST_CHECK: begin
`ifdef BIT_UNSTUFF_ERR_EN
                    if (!d_orig) begin
                        w_stuff_drop_nxt = 1'b1;
                        w_ones_nxt       = '0;
                        w_state_nxt      = ST_RUN;
                    end else begin
                        w_stuff_err_nxt = 1'b1;
                        w_state_nxt     = ST_ERR;
                    end
`else
                    // without error checking the stuff slot is dropped whatever its value
                    w_stuff_drop_nxt = 1'b1;
                    w_ones_nxt       = '0;
                    w_state_nxt      = ST_RUN;
`endif
                end
`ifdef BIT_UNSTUFF_ERR_EN
                ST_ERR: begin
                    w_state_nxt = ST_ERR;
                end
`endif
                default: begin
                    w_state_nxt = ST_RUN;
                    w_ones_nxt  = '0;
                end
            endcase
        end
    end

    assign bit_out    = r_bit_out;
    assign bit_valid  = r_bit_valid;
    assign stuff_drop = r_stuff_drop;
`ifdef BIT_UNSTUFF_ERR_EN
    assign stuff_err  = r_stuff_err;
`else
    assign stuff_err  = 1'b0;
`endif

endmodule
